// File: rtl/colour_level_mixer.sv
`default_nettype none
// ============================================================================
//  Module   : colour_level_mixer
//  Purpose  : Multi-level colour mixer. Button edges step per-channel levels,
//             a brush/eraser FSM drives the packed colour and paint enable.
//             Optional LED-preview PWM outputs when COLOUR_PWM_EN is defined.
//  Revision : 1.0  initial release
// ============================================================================
module colour_level_mixer #(
    parameter int NUM_CH  = 3,
    parameter int CH_BITS = 2,
    parameter int WRAP    = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_CH-1:0]           ch_btn,
    input  logic                        clr_btn,
    input  logic                        brush_mode,
    output logic [NUM_CH*CH_BITS-1:0]   colour_out,
    output logic                        paint_enable,
    output logic                        colour_chg,
    output logic [1:0]                  mode_state
`ifdef COLOUR_PWM_EN
    ,
    output logic [NUM_CH-1:0]           pwm_out
`endif
);

    localparam int                 c_W       = NUM_CH * CH_BITS;
    localparam logic [CH_BITS-1:0] c_LVL_MAX = '1;

    typedef enum logic [1:0] {
        c_ST_MOVE  = 2'b00,
        c_ST_PAINT = 2'b01,
        c_ST_ERASE = 2'b10
    } state_t;

    logic [NUM_CH-1:0] r_btn_q;
    logic              r_clr_q;
    logic [c_W-1:0]    r_lvl;
    state_t            r_state;
    logic [c_W-1:0]    r_colour_out;
    logic              r_paint_enable;
    logic              r_colour_chg;

    logic [NUM_CH-1:0] w_step;
    logic              w_clr_edge;
    logic [c_W-1:0]    w_lvl_nxt;
    state_t            w_state_nxt;
    logic [c_W-1:0]    w_colour_nxt;
    logic              w_paint_nxt;

    assign w_step     = ch_btn & ~r_btn_q;
    assign w_clr_edge = clr_btn & ~r_clr_q;

    // Clear wins over any step arriving in the same cycle
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [CH_BITS-1:0] w_cur;
        logic [CH_BITS-1:0] w_inc;

        assign w_cur = r_lvl[c*CH_BITS +: CH_BITS];

        if (WRAP != 0) begin : g_wrap
            assign w_inc = w_cur + 1'b1;
        end else begin : g_sat
            assign w_inc = (w_cur == c_LVL_MAX) ? w_cur : w_cur + 1'b1;
        end

        assign w_lvl_nxt[c*CH_BITS +: CH_BITS] =
            w_clr_edge ? '0 : (w_step[c] ? w_inc : w_cur);
    end

    // Mode follows the already-updated levels, so outputs trail a step by one cycle
    always_comb begin
        w_state_nxt  = c_ST_MOVE;
        w_colour_nxt = '0;
        w_paint_nxt  = 1'b0;
        if (!brush_mode) begin
            w_state_nxt = c_ST_ERASE;
        end else if (|r_lvl) begin
            w_state_nxt = c_ST_PAINT;
        end
        case (w_state_nxt)
            c_ST_PAINT: begin
                w_colour_nxt = r_lvl;
                w_paint_nxt  = 1'b1;
            end
            c_ST_ERASE: begin
                w_paint_nxt  = 1'b1;
            end
            default: begin
                w_colour_nxt = r_lvl;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_btn_q        <= '0;
            r_clr_q        <= 1'b0;
            r_lvl          <= '0;
            r_state        <= c_ST_MOVE;
            r_colour_out   <= '0;
            r_paint_enable <= 1'b0;
            r_colour_chg   <= 1'b0;
        end else begin
            r_btn_q        <= ch_btn;
            r_clr_q        <= clr_btn;
            r_lvl          <= w_lvl_nxt;
            r_state        <= w_state_nxt;
            r_colour_out   <= w_colour_nxt;
            r_paint_enable <= w_paint_nxt;
            r_colour_chg   <= (w_colour_nxt != r_colour_out);
        end
    end

    assign colour_out   = r_colour_out;
    assign paint_enable = r_paint_enable;
    assign colour_chg   = r_colour_chg;
    assign mode_state   = r_state;

`ifdef COLOUR_PWM_EN
    logic [CH_BITS-1:0] r_pwm_cnt;
    logic [NUM_CH-1:0]  r_pwm_out;

    // Compare against the displayed colour so ERASE and MOVE give zero duty
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pwm_cnt <= '0;
            r_pwm_out <= '0;
        end else begin
            r_pwm_cnt <= r_pwm_cnt + 1'b1;
            for (int c = 0; c < NUM_CH; c++) begin
                r_pwm_out[c] <= (r_pwm_cnt < r_colour_out[c*CH_BITS +: CH_BITS]);
            end
        end
    end

    assign pwm_out = r_pwm_out;
`endif

endmodule
`default_nettype wire
